// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse letter datapath:
//   - symbol encoding (dot / dash)
//   - letter select encoding (A..H on a 3-bit switch bank)
//   - MAX_LEN, the longest letter in symbols
//   - pattern and length ROMs for the eight supported letters
// Patterns are stored with the first symbol in bit 0 so the shift register
// can present symbols by shifting right. A 1 bit is a dash.
// -----------------------------------------------------------------------------
package morse_pkg;

  localparam int MAX_LEN = 4;

  typedef enum logic {
    SYM_DOT  = 1'b0,
    SYM_DASH = 1'b1
  } sym_e;

  typedef enum logic [2:0] {
    LTR_A = 3'd0,
    LTR_B = 3'd1,
    LTR_C = 3'd2,
    LTR_D = 3'd3,
    LTR_E = 3'd4,
    LTR_F = 3'd5,
    LTR_G = 3'd6,
    LTR_H = 3'd7
  } ltr_e;

  // Symbol pattern for a letter, first symbol in bit 0, zero above the length.
  function automatic logic [MAX_LEN-1:0] ltr_pattern(input logic [2:0] ltr);
    logic [MAX_LEN-1:0] pat;
    pat = '0;
    case (ltr_e'(ltr))
      LTR_A:   pat = 4'b0010;  // .-
      LTR_B:   pat = 4'b0001;  // -...
      LTR_C:   pat = 4'b0101;  // -.-.
      LTR_D:   pat = 4'b0001;  // -..
      LTR_E:   pat = 4'b0000;  // .
      LTR_F:   pat = 4'b0100;  // ..-.
      LTR_G:   pat = 4'b0011;  // --.
      LTR_H:   pat = 4'b0000;  // ....
      default: pat = '0;
    endcase
    return pat;
  endfunction

  // Number of symbols in a letter (1..MAX_LEN).
  function automatic logic [2:0] ltr_len(input logic [2:0] ltr);
    logic [2:0] len;
    len = 3'd0;
    case (ltr_e'(ltr))
      LTR_A:   len = 3'd2;
      LTR_B:   len = 3'd4;
      LTR_C:   len = 3'd4;
      LTR_D:   len = 3'd3;
      LTR_E:   len = 3'd1;
      LTR_F:   len = 3'd4;
      LTR_G:   len = 3'd3;
      LTR_H:   len = 3'd4;
      default: len = 3'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous level (e.g. a push button) into the clk domain
// through a SYNC_STAGES flop chain, then emits a one-cycle pulse on each
// rising edge of the synchronised level. A held level gives one pulse.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high; clears the chain and edge flop
//   din    in   asynchronous level input
//   rise   out  one-cycle pulse when the synchronised level goes 0->1
// -----------------------------------------------------------------------------
module sync_edge_det #(
  parameter int SYNC_STAGES = 2   // minimum 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples its pre-edge neighbour; blocking would collapse the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/morse_symbol_source.sv
// -----------------------------------------------------------------------------
// morse_symbol_source
// Upstream datapath stage for the Morse letter FSM. A press of the load
// button captures the letter select and loads that letter's pattern and
// length. The current symbol and the remaining-symbol count are presented
// to the FSM, which pulses sym_adv each time it has consumed a symbol.
// The block is idle when sym_left is 0 and busy otherwise; a load request
// while busy is dropped, not queued.
//
// Ports:
//   clk        in   system clock (50 MHz)
//   reset      in   synchronous, active-high
//   in_ltr     in   [2:0] letter select, 0=A .. 7=H, quasi-static
//   ld_ltr     in   load button level, asynchronous to clk
//   sym_adv    in   one-cycle pulse: current symbol consumed
//   cur_sym    out  current symbol, 0=dot 1=dash (meaningful when sym_valid)
//   sym_left   out  [2:0] symbols remaining including the current one
//   sym_valid  out  high while sym_left != 0
//   ltr_start  out  one-cycle pulse on the cycle a letter is loaded
//   ltr_done   out  one-cycle pulse on the cycle the last symbol is consumed
// -----------------------------------------------------------------------------
module morse_symbol_source
  import morse_pkg::ltr_pattern, morse_pkg::ltr_len;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] in_ltr,
  input  logic       ld_ltr,
  input  logic       sym_adv,
  output logic       cur_sym,
  output logic [2:0] sym_left,
  output logic       sym_valid,
  output logic       ltr_start,
  output logic       ltr_done
);

  logic               load_edge;
  logic [MAX_LEN-1:0] shreg;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ld_sync (
    .clk   (clk),
    .reset (reset),
    .din   (ld_ltr),
    .rise  (load_edge)
  );

  // Decode of the current step. The idle/busy state lives entirely in
  // sym_left, so there is no separate state register to keep in step.
  logic idle;
  logic do_load;
  logic do_adv;
  logic last_sym;

  assign idle     = (sym_left == 3'd0);
  assign do_load  = idle & load_edge;    // load only when idle
  assign do_adv   = ~idle & sym_adv;     // advance only when busy
  assign last_sym = (sym_left == 3'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg     <= '0;
      sym_left  <= 3'd0;
      sym_valid <= 1'b0;
      ltr_start <= 1'b0;
      ltr_done  <= 1'b0;
    end else begin
      ltr_start <= do_load;
      ltr_done  <= do_adv & last_sym;

      if (do_load) begin
        shreg     <= MAX_LEN'(ltr_pattern(in_ltr));
        sym_left  <= ltr_len(in_ltr);
        sym_valid <= 1'b1;
      end else if (do_adv) begin
        // Clearing on the last symbol keeps cur_sym at 0 while idle.
        shreg     <= last_sym ? '0 : (shreg >> 1);
        sym_left  <= sym_left - 3'd1;
        sym_valid <= ~last_sym;
      end
    end
  end

  // Bit 0 of the shift register is the symbol being presented.
  assign cur_sym = shreg[0];

endmodule
